// File: rtl/peripheral_bus_pkg.sv
// rtl/peripheral_bus_pkg.sv - shared types and constants for the peripheral bus controller
package peripheral_bus_pkg;

   localparam int PBUS_ADDR_WIDTH = 24;
   localparam int PBUS_DATA_WIDTH = 32;
   localparam int PBUS_SEL_WIDTH  = 4;

   // Returned to the master for reads nobody claims and for aborted accesses
   localparam logic [PBUS_DATA_WIDTH-1:0] PBUS_UNMAPPED_DATA = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      PBUS_IDLE   = 2'd0,
      PBUS_ACCESS = 2'd1,
      PBUS_DONE   = 2'd2,
      PBUS_ERROR  = 2'd3
   } pbus_state_t;

endpackage

// File: rtl/peripheral_bus_controller_if.sv
// rtl/peripheral_bus_controller_if.sv - Wishbone slave side and peripheral bus signals of the controller
interface peripheral_bus_controller_if import peripheral_bus_pkg::*;;

   logic                       wb_cyc_i;
   logic                       wb_stb_i;
   logic                       wb_we_i;
   logic [PBUS_SEL_WIDTH-1:0]  wb_sel_i;
   logic [PBUS_ADDR_WIDTH-1:0] wb_adr_i;
   logic [PBUS_DATA_WIDTH-1:0] wb_dat_i;
   logic                       wb_ack_o;
   logic                       wb_err_o;
   logic [PBUS_DATA_WIDTH-1:0] wb_dat_o;

   logic                       peripheralBus_we;
   logic                       peripheralBus_oe;
   logic                       peripheralBus_busy;
   logic [PBUS_ADDR_WIDTH-1:0] peripheralBus_address;
   logic [PBUS_SEL_WIDTH-1:0]  peripheralBus_byteSelect;
   logic [PBUS_DATA_WIDTH-1:0] peripheralBus_dataWrite;
   logic [PBUS_DATA_WIDTH-1:0] peripheralBus_dataRead;
   logic                       requestOutput;

   // Controller view: Wishbone slave toward the core, initiator toward the responders
   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
      output wb_ack_o, wb_err_o, wb_dat_o,
      output peripheralBus_we, peripheralBus_oe,
      output peripheralBus_address, peripheralBus_byteSelect, peripheralBus_dataWrite,
      input  peripheralBus_busy, peripheralBus_dataRead, requestOutput
   );

   // Environment view: Wishbone master plus the responder side
   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
      input  wb_ack_o, wb_err_o, wb_dat_o,
      input  peripheralBus_we, peripheralBus_oe,
      input  peripheralBus_address, peripheralBus_byteSelect, peripheralBus_dataWrite,
      output peripheralBus_busy, peripheralBus_dataRead, requestOutput
   );

endinterface

// File: rtl/peripheral_bus_timeout.sv
// rtl/peripheral_bus_timeout.sv - saturating busy-cycle counter with expiry flag
module peripheral_bus_timeout #(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int TIMEOUT_WIDTH  = 9
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   // Expired means the current busy cycle is the last one allowed
   localparam logic [TIMEOUT_WIDTH-1:0] LAST_COUNT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [TIMEOUT_WIDTH-1:0] count;

   // Count busy cycles, clear between accesses, hold at the top value instead of wrapping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != {TIMEOUT_WIDTH{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count >= LAST_COUNT);

endmodule

// File: rtl/peripheral_bus_controller.sv
// rtl/peripheral_bus_controller.sv - Wishbone to peripheral bus initiator; optional timeout via PERIPHERAL_BUS_CONTROLLER_TIMEOUT_EN
module peripheral_bus_controller import peripheral_bus_pkg::*; #(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int TIMEOUT_WIDTH  = 9
) (
   input logic                        clk,
   input logic                        rst,
   peripheral_bus_controller_if.slave bus
);

   if ((TIMEOUT_CYCLES < 2) || ((2 ** TIMEOUT_WIDTH) <= TIMEOUT_CYCLES)) begin : g_bad_timeout_cfg
      $error("peripheral_bus_controller: TIMEOUT_WIDTH too small for TIMEOUT_CYCLES");
   end

   pbus_state_t state, state_next;

   logic                       we_q, we_next;
   logic                       oe_q, oe_next;
   logic                       ack_q, ack_next;
   logic                       err_q, err_next;
   logic [PBUS_DATA_WIDTH-1:0] rdat_q, rdat_next;
   logic [PBUS_ADDR_WIDTH-1:0] adr_q, adr_next;
   logic [PBUS_SEL_WIDTH-1:0]  sel_q, sel_next;
   logic [PBUS_DATA_WIDTH-1:0] wdat_q, wdat_next;
   logic                       tmo_expired;

`ifdef PERIPHERAL_BUS_CONTROLLER_TIMEOUT_EN
   logic tmo_clear;
   logic tmo_enable;

   // Idle always precedes ACCESS, so clearing there zeroes the count on entry
   assign tmo_clear  = (state == PBUS_IDLE);
   assign tmo_enable = (state == PBUS_ACCESS) && bus.peripheralBus_busy;

   peripheral_bus_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (tmo_clear),
      .enable  (tmo_enable),
      .expired (tmo_expired)
   );
`else
   assign tmo_expired = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= PBUS_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and next values of every registered output
   always_comb begin
      state_next = state;
      we_next    = we_q;
      oe_next    = oe_q;
      ack_next   = 1'b0;
      err_next   = 1'b0;
      rdat_next  = rdat_q;
      adr_next   = adr_q;
      sel_next   = sel_q;
      wdat_next  = wdat_q;

      case (state)
         PBUS_IDLE: begin
            rdat_next = '0;
            if (bus.wb_cyc_i && bus.wb_stb_i) begin
               adr_next   = bus.wb_adr_i;
               sel_next   = bus.wb_sel_i;
               wdat_next  = bus.wb_dat_i;
               we_next    = bus.wb_we_i;
               oe_next    = !bus.wb_we_i;
               state_next = PBUS_ACCESS;
            end
         end
         PBUS_ACCESS: begin
            if (!bus.peripheralBus_busy) begin
               // Completion runs even if the master left; only the ack is withheld
               we_next    = 1'b0;
               oe_next    = 1'b0;
               ack_next   = bus.wb_cyc_i;
               rdat_next  = we_q ? '0 :
                            (bus.requestOutput ? bus.peripheralBus_dataRead : PBUS_UNMAPPED_DATA);
               state_next = PBUS_DONE;
            end else if (tmo_expired) begin
               we_next    = 1'b0;
               oe_next    = 1'b0;
               err_next   = bus.wb_cyc_i;
               rdat_next  = PBUS_UNMAPPED_DATA;
               state_next = PBUS_ERROR;
            end
         end
         PBUS_DONE: begin
            rdat_next  = '0;
            state_next = PBUS_IDLE;
         end
         PBUS_ERROR: begin
            rdat_next  = '0;
            state_next = PBUS_IDLE;
         end
         default: begin
            state_next = PBUS_IDLE;
         end
      endcase
   end

   // Output and latched-field registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q   <= 1'b0;
         oe_q   <= 1'b0;
         ack_q  <= 1'b0;
         err_q  <= 1'b0;
         rdat_q <= '0;
         adr_q  <= '0;
         sel_q  <= '0;
         wdat_q <= '0;
      end else begin
         we_q   <= we_next;
         oe_q   <= oe_next;
         ack_q  <= ack_next;
         err_q  <= err_next;
         rdat_q <= rdat_next;
         adr_q  <= adr_next;
         sel_q  <= sel_next;
         wdat_q <= wdat_next;
      end
   end

   assign bus.wb_ack_o                 = ack_q;
   assign bus.wb_err_o                 = err_q;
   assign bus.wb_dat_o                 = rdat_q;
   assign bus.peripheralBus_we         = we_q;
   assign bus.peripheralBus_oe         = oe_q;
   assign bus.peripheralBus_address    = adr_q;
   assign bus.peripheralBus_byteSelect = sel_q;
   assign bus.peripheralBus_dataWrite  = wdat_q;

endmodule

// File: tb/tb_peripheral_bus_controller.sv
// tb/tb_peripheral_bus_controller.sv - directed self-checking bench for peripheral_bus_controller
`timescale 1ns/1ps
module tb_peripheral_bus_controller;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   peripheral_bus_controller_if bus_if ();

   peripheral_bus_controller #(
      .TIMEOUT_CYCLES (8),
      .TIMEOUT_WIDTH  (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic request(input logic we, input logic [23:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
      bus_if.wb_cyc_i = 1'b1;
      bus_if.wb_stb_i = 1'b1;
      bus_if.wb_we_i  = we;
      bus_if.wb_adr_i = adr;
      bus_if.wb_dat_i = dat;
      bus_if.wb_sel_i = sel;
   endtask

   task automatic release_bus();
      bus_if.wb_cyc_i = 1'b0;
      bus_if.wb_stb_i = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus_if.wb_cyc_i = 1'b0;
      bus_if.wb_stb_i = 1'b0;
      bus_if.wb_we_i  = 1'b0;
      bus_if.wb_sel_i = 4'h0;
      bus_if.wb_adr_i = 24'h0;
      bus_if.wb_dat_i = 32'h0;
      bus_if.peripheralBus_busy     = 1'b0;
      bus_if.peripheralBus_dataRead = 32'h0;
      bus_if.requestOutput          = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_we",   32'(bus_if.peripheralBus_we), 32'h0);
      check("rst_oe",   32'(bus_if.peripheralBus_oe), 32'h0);
      check("rst_ack",  32'(bus_if.wb_ack_o), 32'h0);
      check("rst_err",  32'(bus_if.wb_err_o), 32'h0);
      check("rst_dato", bus_if.wb_dat_o, 32'h0);
      check("rst_adr",  32'(bus_if.peripheralBus_address), 32'h0);
      check("rst_wdat", bus_if.peripheralBus_dataWrite, 32'h0);
      rst = 1'b0;
      tick();

      // Write, no busy: strobe at N+1, ack at N+2
      request(1'b1, 24'h001004, 32'hA5A5_0001, 4'hF);
      tick();
      check("wr_we",   32'(bus_if.peripheralBus_we), 32'h1);
      check("wr_oe",   32'(bus_if.peripheralBus_oe), 32'h0);
      check("wr_adr",  32'(bus_if.peripheralBus_address), 32'h0000_1004);
      check("wr_sel",  32'(bus_if.peripheralBus_byteSelect), 32'hF);
      check("wr_wdat", bus_if.peripheralBus_dataWrite, 32'hA5A5_0001);
      check("wr_ack_early", 32'(bus_if.wb_ack_o), 32'h0);
      tick();
      check("wr_we_drop", 32'(bus_if.peripheralBus_we), 32'h0);
      check("wr_ack",     32'(bus_if.wb_ack_o), 32'h1);
      check("wr_dato",    bus_if.wb_dat_o, 32'h0);
      release_bus();
      tick();
      check("wr_ack_once", 32'(bus_if.wb_ack_o), 32'h0);

      // Mapped read
      bus_if.requestOutput          = 1'b1;
      bus_if.peripheralBus_dataRead = 32'h1234_5678;
      request(1'b0, 24'h000020, 32'h0, 4'hF);
      tick();
      check("rd_oe", 32'(bus_if.peripheralBus_oe), 32'h1);
      check("rd_we", 32'(bus_if.peripheralBus_we), 32'h0);
      tick();
      check("rd_oe_drop", 32'(bus_if.peripheralBus_oe), 32'h0);
      check("rd_ack",     32'(bus_if.wb_ack_o), 32'h1);
      check("rd_dato",    bus_if.wb_dat_o, 32'h1234_5678);
      check("rd_err",     32'(bus_if.wb_err_o), 32'h0);
      release_bus();
      tick();
      check("rd_ack_once", 32'(bus_if.wb_ack_o), 32'h0);

      // Unmapped read
      bus_if.requestOutput = 1'b0;
      request(1'b0, 24'h00FFF0, 32'h0, 4'h3);
      tick();
      check("um_oe", 32'(bus_if.peripheralBus_oe), 32'h1);
      tick();
      check("um_ack",  32'(bus_if.wb_ack_o), 32'h1);
      check("um_dato", bus_if.wb_dat_o, 32'hFFFF_FFFF);
      release_bus();
      tick();

      // Busy for 5 cycles: strobe high 6 cycles, ack at N+7
      bus_if.peripheralBus_busy = 1'b1;
      request(1'b1, 24'h002008, 32'h0BAD_F00D, 4'h1);
      tick();
      check("bz_we_first", 32'(bus_if.peripheralBus_we), 32'h1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bz_we_hold",  32'(bus_if.peripheralBus_we), 32'h1);
         check("bz_adr_hold", 32'(bus_if.peripheralBus_address), 32'h0000_2008);
         check("bz_no_ack",   32'(bus_if.wb_ack_o), 32'h0);
      end
      bus_if.peripheralBus_busy = 1'b0;
      tick();
      check("bz_we_drop", 32'(bus_if.peripheralBus_we), 32'h0);
      check("bz_ack",     32'(bus_if.wb_ack_o), 32'h1);
      release_bus();
      tick();
      check("bz_ack_once", 32'(bus_if.wb_ack_o), 32'h0);

      // Master abandons the cycle mid-access: access completes, no ack
      bus_if.peripheralBus_busy = 1'b1;
      bus_if.requestOutput      = 1'b1;
      request(1'b0, 24'h000040, 32'h0, 4'hF);
      tick();
      check("cd_oe", 32'(bus_if.peripheralBus_oe), 32'h1);
      release_bus();
      tick();
      check("cd_oe_hold", 32'(bus_if.peripheralBus_oe), 32'h1);
      bus_if.peripheralBus_busy = 1'b0;
      tick();
      check("cd_oe_drop", 32'(bus_if.peripheralBus_oe), 32'h0);
      check("cd_no_ack",  32'(bus_if.wb_ack_o), 32'h0);
      tick();
      check("cd_no_ack2", 32'(bus_if.wb_ack_o), 32'h0);

      // Reset in the middle of an access drops the strobe without waiting for a clock
      bus_if.peripheralBus_busy = 1'b1;
      request(1'b1, 24'h000080, 32'h5555_AAAA, 4'hF);
      tick();
      check("ra_we", 32'(bus_if.peripheralBus_we), 32'h1);
      #1;
      rst = 1'b1;
      #1;
      check("ra_we_async", 32'(bus_if.peripheralBus_we), 32'h0);
      check("ra_adr_async", 32'(bus_if.peripheralBus_address), 32'h0);
      release_bus();
      bus_if.peripheralBus_busy = 1'b0;
      tick();
      #2;
      rst = 1'b0;
      tick();
      check("ra_no_ack", 32'(bus_if.wb_ack_o), 32'h0);
      check("ra_we_low", 32'(bus_if.peripheralBus_we), 32'h0);
      request(1'b1, 24'h000084, 32'h0000_0042, 4'h2);
      tick();
      check("ra_next_we", 32'(bus_if.peripheralBus_we), 32'h1);
      tick();
      check("ra_next_ack", 32'(bus_if.wb_ack_o), 32'h1);
      release_bus();
      tick();

`ifdef PERIPHERAL_BUS_CONTROLLER_TIMEOUT_EN
      // Stuck busy: strobe high 8 cycles, then one error pulse and no ack
      bus_if.peripheralBus_busy = 1'b1;
      request(1'b0, 24'h000100, 32'h0, 4'hF);
      tick();
      check("to_oe_first", 32'(bus_if.peripheralBus_oe), 32'h1);
      for (int i = 0; i < 7; i++) begin
         tick();
         check("to_oe_hold", 32'(bus_if.peripheralBus_oe), 32'h1);
         check("to_no_err",  32'(bus_if.wb_err_o), 32'h0);
      end
      tick();
      check("to_oe_drop", 32'(bus_if.peripheralBus_oe), 32'h0);
      check("to_err",     32'(bus_if.wb_err_o), 32'h1);
      check("to_no_ack",  32'(bus_if.wb_ack_o), 32'h0);
      check("to_dato",    bus_if.wb_dat_o, 32'hFFFF_FFFF);
      release_bus();
      bus_if.peripheralBus_busy = 1'b0;
      tick();
      check("to_err_once", 32'(bus_if.wb_err_o), 32'h0);
      bus_if.peripheralBus_dataRead = 32'hCAFE_0001;
      request(1'b0, 24'h000104, 32'h0, 4'hF);
      tick();
      tick();
      check("to_next_ack",  32'(bus_if.wb_ack_o), 32'h1);
      check("to_next_dato", bus_if.wb_dat_o, 32'hCAFE_0001);
      release_bus();
      tick();
`else
      // Without the timeout, a long busy stretch simply holds the access
      bus_if.peripheralBus_busy = 1'b1;
      request(1'b0, 24'h000100, 32'h0, 4'hF);
      tick();
      for (int i = 0; i < 12; i++) begin
         tick();
         check("nt_oe_hold", 32'(bus_if.peripheralBus_oe), 32'h1);
         check("nt_no_err",  32'(bus_if.wb_err_o), 32'h0);
      end
      bus_if.peripheralBus_dataRead = 32'hCAFE_0001;
      bus_if.peripheralBus_busy = 1'b0;
      tick();
      check("nt_ack",  32'(bus_if.wb_ack_o), 32'h1);
      check("nt_dato", bus_if.wb_dat_o, 32'hCAFE_0001);
      release_bus();
      tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
